// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the trainable perceptron: FSM state encoding,
// a constant-foldable ceil-log2 and the saturating weight-step function.
package perceptron_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      DECIDE = 2'd2,
      UPDATE = 2'd3
   } state_t;

   // Ceil-log2, usable in parameter/localparam expressions.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Adds step to weight and clamps the result to the signed range of a
   // wt_w-bit word; the caller truncates the returned int to wt_w bits.
   function automatic int sat_add(input int weight, input int step, input int wt_w);
      int sum;
      int hi;
      int lo;
      sum = weight + step;
      hi  = (1 <<< (wt_w - 1)) - 1;
      lo  = -(1 <<< (wt_w - 1));
      if (sum > hi)      return hi;
      else if (sum < lo) return lo;
      else               return sum;
   endfunction

endpackage

// File: rtl/perceptron_wt_bank.sv
// Weight register file for perceptron_learn: N_IN signed weights reset to
// WT_INIT, one read port for the serial datapath, one for observation, and a
// single write port that applies a saturating +/- step to the addressed weight.
module perceptron_wt_bank
   import perceptron_pkg::*;
#(
   parameter  int N_IN    = 8,
   parameter  int WT_W    = 8,
   parameter  int WT_INIT = 0,
   localparam int IDX_W   = clog2(N_IN)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [IDX_W-1:0]       i_rd_idx,
   input  logic [IDX_W-1:0]       i_obs_idx,
   input  logic                   i_we,
   input  logic [IDX_W-1:0]       i_wr_idx,
   input  logic signed [WT_W-1:0] i_step,
   output logic signed [WT_W-1:0] o_rd_wt,
   output logic signed [WT_W-1:0] o_obs_wt
);

   localparam logic signed [WT_W-1:0] WT_INIT_V = WT_W'(WT_INIT);

   logic signed [WT_W-1:0] r_wt [N_IN];
   logic signed [WT_W-1:0] w_new;
   logic signed [WT_W-1:0] w_cur;

   // Combinational reads; indices past the last weight read as zero.
   always_comb begin
      o_rd_wt  = '0;
      o_obs_wt = '0;
      w_cur    = '0;
      if (int'(i_rd_idx) < N_IN)  o_rd_wt  = r_wt[i_rd_idx];
      if (int'(i_obs_idx) < N_IN) o_obs_wt = r_wt[i_obs_idx];
      if (int'(i_wr_idx) < N_IN)  w_cur    = r_wt[i_wr_idx];
      w_new = WT_W'(sat_add(int'(w_cur), int'(i_step), WT_W));
   end

   // Weight storage: reset to WT_INIT, otherwise saturating write.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < N_IN; i++) r_wt[i] <= WT_INIT_V;
      end else if (i_we && (int'(i_wr_idx) < N_IN)) begin
         r_wt[i_wr_idx] <= w_new;
      end
   end

endmodule

// File: rtl/perceptron_learn.sv
// Trainable single-layer perceptron. Accepts a binary feature vector over
// in_valid/in_ready, accumulates the selected weights one per cycle, applies a
// step activation against THRESH and, in training mode, runs the perceptron
// learning rule (+/-LR, saturating) over the active inputs on a misprediction.
// Optional feature macro: PERCEPTRON_BIAS_EN adds a learned bias and bias_out.
module perceptron_learn
   import perceptron_pkg::*;
#(
   parameter  int N_IN    = 8,
   parameter  int WT_W    = 8,
   parameter  int LR      = 1,
   parameter  int THRESH  = 0,
   parameter  int WT_INIT = 0,
   localparam int IDX_W   = clog2(N_IN)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_IN-1:0]        in_vec,
   input  logic                   train,
   input  logic                   exp_res,
   output logic                   out_valid,
   output logic                   result,
   output logic                   updated,
   output logic [15:0]            err_cnt,
   input  logic [IDX_W-1:0]       wt_sel,
   output logic signed [WT_W-1:0] wt_out
`ifdef PERCEPTRON_BIAS_EN
   ,
   output logic signed [WT_W-1:0] bias_out
`endif
);

   // One spare bit beyond the worst-case sum so the accumulator never wraps.
   localparam int ACC_W = WT_W + clog2(N_IN + 1) + 1;
   localparam logic signed [ACC_W-1:0] THR_V     = ACC_W'(THRESH);
   localparam logic signed [WT_W-1:0]  LR_V      = WT_W'(LR);
   localparam logic signed [WT_W-1:0]  WT_INIT_V = WT_W'(WT_INIT);
   localparam logic [IDX_W-1:0]        LAST_IDX  = IDX_W'(N_IN - 1);

   state_t                  r_state;
   logic                    r_in_ready;
   logic [IDX_W-1:0]        r_idx;
   logic [N_IN-1:0]         r_vec;
   logic                    r_train;
   logic                    r_exp;
   logic signed [ACC_W-1:0] r_acc;
   logic                    r_result;
   logic                    r_ov_pend;
   logic                    r_out_valid;
   logic                    r_upd_pend;
   logic                    r_updated;
   logic [15:0]             r_err_cnt;

   logic signed [WT_W-1:0]  w_rd_wt;
   logic signed [ACC_W-1:0] w_wt_ext;
   logic signed [ACC_W-1:0] w_sum;
   logic signed [WT_W-1:0]  w_step;
   logic                    w_res;
   logic                    w_we;
   logic                    w_last;

   assign w_wt_ext = {{(ACC_W - WT_W){w_rd_wt[WT_W-1]}}, w_rd_wt};
   assign w_step   = r_exp ? LR_V : -LR_V;
   assign w_last   = (r_idx == LAST_IDX);
   assign w_we     = (r_state == UPDATE) && r_vec[r_idx];

`ifdef PERCEPTRON_BIAS_EN
   logic signed [WT_W-1:0]  r_bias;
   logic signed [ACC_W-1:0] w_bias_ext;

   assign w_bias_ext = {{(ACC_W - WT_W){r_bias[WT_W-1]}}, r_bias};
   assign w_sum      = r_acc + w_bias_ext;
   assign bias_out   = r_bias;

   // Bias acts as an always-active input, stepped alongside weight 0.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_bias <= WT_INIT_V;
      end else if ((r_state == UPDATE) && (r_idx == '0)) begin
         r_bias <= WT_W'(sat_add(int'(r_bias), int'(w_step), WT_W));
      end
   end
`else
   assign w_sum = r_acc;
`endif

   assign w_res = (w_sum >= THR_V);

   perceptron_wt_bank #(
      .N_IN    (N_IN),
      .WT_W    (WT_W),
      .WT_INIT (WT_INIT)
   ) u_wt_bank (
      .clk       (clk),
      .reset     (reset),
      .i_rd_idx  (r_idx),
      .i_obs_idx (wt_sel),
      .i_we      (w_we),
      .i_wr_idx  (r_idx),
      .i_step    (w_step),
      .o_rd_wt   (w_rd_wt),
      .o_obs_wt  (wt_out)
   );

   // Capture stage: latch the offered vector and its training controls.
   always_ff @(posedge clk) begin
      if ((r_state == IDLE) && in_valid) begin
         r_vec   <= in_vec;
         r_train <= train;
         r_exp   <= exp_res;
      end
   end

   // Accumulator: cleared on accept, adds the weight of each active input.
   always_ff @(posedge clk) begin
      if ((r_state == IDLE) && in_valid) begin
         r_acc <= '0;
      end else if ((r_state == ACCUM) && r_vec[r_idx]) begin
         r_acc <= r_acc + w_wt_ext;
      end
   end

   // Control FSM with registered handshake, result, pulses and error count.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_idx       <= '0;
         r_result    <= 1'b0;
         r_ov_pend   <= 1'b0;
         r_out_valid <= 1'b0;
         r_upd_pend  <= 1'b0;
         r_updated   <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         // Result/update pulses trail their trigger by one cycle.
         r_out_valid <= r_ov_pend;
         r_ov_pend   <= 1'b0;
         r_updated   <= r_upd_pend;
         r_upd_pend  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_idx      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= ACCUM;
               end
            end
            ACCUM: begin
               if (w_last) r_state <= DECIDE;
               else        r_idx   <= r_idx + 1'b1;
            end
            DECIDE: begin
               r_result  <= w_res;
               r_ov_pend <= 1'b1;
               if (r_train && (w_res != r_exp)) begin
                  if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                  r_idx   <= '0;
                  r_state <= UPDATE;
               end else begin
                  r_in_ready <= 1'b1;
                  r_state    <= IDLE;
               end
            end
            UPDATE: begin
               if (w_last) begin
                  r_upd_pend <= 1'b1;
                  r_in_ready <= 1'b1;
                  r_state    <= IDLE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: begin
               r_in_ready <= 1'b1;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign updated   = r_updated;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_perceptron_learn.sv
// Bench for perceptron_learn: a default-parameter instance (u_a) and a
// THRESH=-200 instance (u_b) share the input drivers; each has its own reset
// and the unused one is held in reset. Outputs are muxed by sel_b.
module tb_perceptron_learn;

   logic       clk = 1'b0;
   logic       rst_a, rst_b;
   logic       in_valid, train, exp_res;
   logic [7:0] in_vec;
   logic [2:0] wt_sel;

   logic              a_in_ready, a_out_valid, a_result, a_updated;
   logic [15:0]       a_err_cnt;
   logic signed [7:0] a_wt_out;
   logic              b_in_ready, b_out_valid, b_result, b_updated;
   logic [15:0]       b_err_cnt;
   logic signed [7:0] b_wt_out;

   logic              m_in_ready, m_out_valid, m_result, m_updated;
   logic [15:0]       m_err_cnt;
   logic [7:0]        m_wt_out;
   bit                sel_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

`ifdef PERCEPTRON_BIAS_EN
   logic signed [7:0] a_bias, b_bias;
`endif

   perceptron_learn #(.N_IN(8), .WT_W(8), .LR(1), .THRESH(0), .WT_INIT(0)) u_a (
      .clk(clk), .reset(rst_a), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_vec(in_vec), .train(train), .exp_res(exp_res), .out_valid(a_out_valid),
      .result(a_result), .updated(a_updated), .err_cnt(a_err_cnt),
      .wt_sel(wt_sel), .wt_out(a_wt_out)
`ifdef PERCEPTRON_BIAS_EN
      , .bias_out(a_bias)
`endif
   );

   perceptron_learn #(.N_IN(8), .WT_W(8), .LR(1), .THRESH(-200), .WT_INIT(0)) u_b (
      .clk(clk), .reset(rst_b), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_vec(in_vec), .train(train), .exp_res(exp_res), .out_valid(b_out_valid),
      .result(b_result), .updated(b_updated), .err_cnt(b_err_cnt),
      .wt_sel(wt_sel), .wt_out(b_wt_out)
`ifdef PERCEPTRON_BIAS_EN
      , .bias_out(b_bias)
`endif
   );

   always_comb begin
      m_in_ready  = sel_b ? b_in_ready  : a_in_ready;
      m_out_valid = sel_b ? b_out_valid : a_out_valid;
      m_result    = sel_b ? b_result    : a_result;
      m_updated   = sel_b ? b_updated   : a_updated;
      m_err_cnt   = sel_b ? b_err_cnt   : a_err_cnt;
      m_wt_out    = sel_b ? b_wt_out    : a_wt_out;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!m_in_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!m_in_ready) check("in_ready_timeout", 32'd0, 32'd1);
   endtask

   // Offers one vector, returns cycles accept->out_valid, the result, and the
   // cycles out_valid->updated (0 when no updated pulse within 10 cycles).
   task automatic run_vec(input logic [7:0] v, input logic t, input logic e,
                          output int lat, output logic res, output int ulat);
      wait_ready();
      in_vec = v; train = t; exp_res = e; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = -1; res = 1'b0; ulat = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (m_out_valid) begin lat = c; res = m_result; break; end
      end
      if (lat > 0) begin
         for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (m_updated) begin ulat = c; break; end
         end
      end
   endtask

   task automatic check_weights(input string name, input logic [63:0] exp_w);
      for (int i = 0; i < 8; i++) begin
         wt_sel = 3'(i);
         #1;
         check($sformatf("%s_w%0d", name, i), {24'd0, m_wt_out}, {24'd0, exp_w[i*8 +: 8]});
      end
   endtask

   typedef struct {
      logic [7:0]  vec;
      logic        trn;
      logic        ex;
      logic        res;
      logic        upd;
      logic [15:0] err;
   } vec_t;

   vec_t tbl[7];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat, ulat, acc2, ov1, ov2, nov;
      logic res, r1, r2, prev_rdy, exp_r;

      tbl[0] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
      tbl[1] = '{8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1};
      tbl[2] = '{8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
      tbl[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2};
      tbl[4] = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2};
      tbl[5] = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2};
      tbl[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2};

      rst_a = 1'b0; rst_b = 1'b0; sel_b = 1'b0;
      in_valid = 1'b0; in_vec = '0; train = 1'b0; exp_res = 1'b0; wt_sel = '0;
      repeat (3) @(posedge clk);
      #1 rst_a = 1'b1;

      // Reset state
      check("rst_in_ready",  {31'd0, m_in_ready},  32'd1);
      check("rst_out_valid", {31'd0, m_out_valid}, 32'd0);
      check("rst_result",    {31'd0, m_result},    32'd0);
      check("rst_updated",   {31'd0, m_updated},   32'd0);
      check("rst_err_cnt",   {16'd0, m_err_cnt},   32'd0);
      check_weights("rst", 64'h0);

      // Table-driven inference/training sequence on default parameters
      for (int i = 0; i < 7; i++) begin
         run_vec(tbl[i].vec, tbl[i].trn, tbl[i].ex, lat, res, ulat);
         check($sformatf("v%0d_latency", i), lat, 32'd10);
         check($sformatf("v%0d_result", i), {31'd0, res}, {31'd0, tbl[i].res});
         check($sformatf("v%0d_upd_lat", i), ulat, tbl[i].upd ? 32'd8 : 32'd0);
         check($sformatf("v%0d_err_cnt", i), {16'd0, m_err_cnt}, {16'd0, tbl[i].err});
         if (i == 1) check_weights("after_v1", 64'h00000000_FFFFFFFF);
      end
      check_weights("after_tbl", 64'h00000000_FFFFFF00);

      // Back-to-back vectors with in_valid held high
      wait_ready();
      in_vec = 8'h03; train = 1'b0; exp_res = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_vec = 8'h0C;
      prev_rdy = m_in_ready;
      check("b2b_ready_low", {31'd0, prev_rdy}, 32'd0);
      acc2 = -1; ov1 = -1; ov2 = -1; nov = 0; r1 = 1'b1; r2 = 1'b1;
      for (int c = 1; c <= 25; c++) begin
         @(posedge clk); #1;
         if (in_valid && prev_rdy) begin acc2 = c; in_valid = 1'b0; end
         if (m_out_valid) begin
            nov++;
            if (nov == 1) begin ov1 = c; r1 = m_result; end
            else if (nov == 2) begin ov2 = c; r2 = m_result; end
         end
         prev_rdy = m_in_ready;
      end
      in_valid = 1'b0;
      check("b2b_accept2", acc2, 32'd10);
      check("b2b_ov_count", nov, 32'd2);
      check("b2b_ov1", ov1, 32'd10);
      check("b2b_ov2", ov2, 32'd20);
      check("b2b_res1", {31'd0, r1}, 32'd0);
      check("b2b_res2", {31'd0, r2}, 32'd0);

      // Reset three cycles into an UPDATE pass
      wait_ready();
      in_vec = 8'h0F; train = 1'b1; exp_res = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (m_out_valid) begin lat = c; break; end
      end
      check("abort_latency", lat, 32'd10);
      @(posedge clk); #1;
      @(posedge clk); #1;
      wt_sel = 3'd0; #1;
      check("abort_w0_pre", {24'd0, m_wt_out}, 32'd1);
      check("abort_err_pre", {16'd0, m_err_cnt}, 32'd3);
      rst_a = 1'b0;
      @(posedge clk); #1;
      rst_a = 1'b1;
      check("abort_in_ready", {31'd0, m_in_ready}, 32'd1);
      check("abort_err_cnt", {16'd0, m_err_cnt}, 32'd0);
      nov = 0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (m_updated || m_out_valid) nov++;
      end
      check("abort_no_pulse", nov, 32'd0);
      check_weights("abort", 64'h0);

`ifdef PERCEPTRON_BIAS_EN
      // Learned bias on an all-zero vector
      run_vec(8'h00, 1'b1, 1'b0, lat, res, ulat);
      check("bias_result1", {31'd0, res}, 32'd1);
      check("bias_upd_lat", ulat, 32'd8);
      check("bias_value", {24'd0, a_bias}, 32'h000000FF);
      check_weights("bias", 64'h0);
      run_vec(8'h00, 1'b0, 1'b0, lat, res, ulat);
      check("bias_result2", {31'd0, res}, 32'd0);
`endif

      // Saturation on the THRESH=-200 instance
      rst_a = 1'b0;
      sel_b = 1'b1;
      rst_b = 1'b1;
      #1;
      for (int i = 0; i < 150; i++) begin
`ifdef PERCEPTRON_BIAS_EN
         exp_r = (i <= 100);
`else
         exp_r = 1'b1;
`endif
         run_vec(8'h01, 1'b1, 1'b0, lat, res, ulat);
         check($sformatf("sat_res_%0d", i), {31'd0, res}, {31'd0, exp_r});
         check($sformatf("sat_upd_%0d", i), ulat, exp_r ? 32'd8 : 32'd0);
      end
`ifdef PERCEPTRON_BIAS_EN
      check("sat_err_cnt", {16'd0, m_err_cnt}, 32'd101);
      check_weights("sat", 64'h00000000_0000009B);
`else
      check("sat_err_cnt", {16'd0, m_err_cnt}, 32'd150);
      check_weights("sat", 64'h00000000_00000080);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
